// File: rtl/seven_segment_capture.sv
// Captures minutes/seconds from a multiplexed, active-low seven-segment display bus.
// Digits are debounced by a run-length counter and assembled into a four-slot frame.
module seven_segment_capture #(
    parameter int unsigned STABLE_CNT = 1
) (
    input  logic        clk_core,
    input  logic        rst_n,
    input  logic [10:0] seven_segment_display_i,
    output logic [5:0]  min_o,
    output logic [5:0]  sec_o,
    output logic        valid_o,
    output logic        err_o
);

    localparam logic [0:0] ST_SYNC    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;
    localparam logic [3:0] STABLE_4   = 4'(STABLE_CNT);

    // Returns {legal, digit}; legal=0 for any pattern outside the ten digits.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = 5'b1_0000;
            7'b1001111: res = 5'b1_0001;
            7'b0010010: res = 5'b1_0010;
            7'b0000110: res = 5'b1_0011;
            7'b1001100: res = 5'b1_0100;
            7'b0100100: res = 5'b1_0101;
            7'b0100000: res = 5'b1_0110;
            7'b0001111: res = 5'b1_0111;
            7'b0000000: res = 5'b1_1000;
            7'b0000100: res = 5'b1_1001;
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    logic [10:0]     smp_r;
    logic [10:0]     prev_r;
    logic [3:0]      cnt_r;
    logic [0:0]      state_r;
    logic [3:0]      mask_r;
    logic [3:0][3:0] dig_r;

    logic            same_s;
    logic [3:0]      cnt_s;
    logic            hit_s;
    logic [3:0]      sel_s;
    logic            blank_s;
    logic            onehot_s;
    logic            bad_anode_s;
    logic [4:0]      dec_s;
    logic            accept_s;
    logic            seg_err_s;
    logic            good_s;

    logic [0:0]      state_n;
    logic [3:0]      mask_n;
    logic [3:0][3:0] dig_n;
    logic [5:0]      min_n;
    logic [5:0]      sec_n;
    logic            valid_n;
    logic            err_n;
    logic [6:0]      min_calc_s;
    logic [6:0]      sec_calc_s;

    // Run-length of the registered sample and acceptance/error qualification.
    always_comb begin
        same_s = (smp_r == prev_r);
        if (!same_s) begin
            cnt_s = 4'd1;
        end else if (cnt_r == 4'd15) begin
            cnt_s = 4'd15;
        end else begin
            cnt_s = cnt_r + 4'd1;
        end
        // A saturated run repeating 15 must not re-accept every cycle.
        hit_s       = (cnt_s == STABLE_4) && !(same_s && (cnt_r == 4'd15));
        sel_s       = ~smp_r[10:7];
        blank_s     = (smp_r[10:7] == 4'b1111);
        onehot_s    = $onehot(sel_s);
        bad_anode_s = !blank_s && !onehot_s && (cnt_s == 4'd1);
        dec_s       = seg_decode(smp_r[6:0]);
        accept_s    = hit_s && onehot_s;
        seg_err_s   = accept_s && !dec_s[4];
        good_s      = accept_s && dec_s[4];
    end

    // Frame assembly: slot bit i of the mask corresponds to anode bit 7+i being low.
    always_comb begin
        state_n    = state_r;
        mask_n     = mask_r;
        dig_n      = dig_r;
        min_n      = min_o;
        sec_n      = sec_o;
        valid_n    = 1'b0;
        err_n      = bad_anode_s | seg_err_s;
        min_calc_s = 7'd0;
        sec_calc_s = 7'd0;
        if (good_s) begin
            if (state_r == ST_SYNC) begin
                if (sel_s == 4'b1000) begin
                    dig_n[3] = dec_s[3:0];
                    mask_n   = 4'b1000;
                    state_n  = ST_COLLECT;
                end else begin
                    state_n = ST_SYNC;
                end
            end else if ((mask_r & sel_s) != 4'b0000) begin
                err_n = 1'b1;
                if (sel_s == 4'b1000) begin
                    dig_n[3] = dec_s[3:0];
                    mask_n   = 4'b1000;
                end else begin
                    mask_n  = 4'b0000;
                    state_n = ST_SYNC;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (sel_s[i]) begin
                        dig_n[i] = dec_s[3:0];
                    end else begin
                        dig_n[i] = dig_r[i];
                    end
                end
                mask_n = mask_r | sel_s;
                if (mask_n == 4'b1111) begin
                    min_calc_s = 7'(dig_n[3]) * 7'd10 + 7'(dig_n[2]);
                    sec_calc_s = 7'(dig_n[1]) * 7'd10 + 7'(dig_n[0]);
                    mask_n     = 4'b0000;
                    state_n    = ST_SYNC;
                    if ((min_calc_s <= 7'd63) && (sec_calc_s <= 7'd63)) begin
                        min_n   = min_calc_s[5:0];
                        sec_n   = sec_calc_s[5:0];
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    state_n = ST_COLLECT;
                end
            end
        end else begin
            state_n = state_r;
        end
    end

    // Input sampling and stability counter.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            smp_r  <= 11'h7FF;
            prev_r <= 11'h7FF;
            cnt_r  <= 4'd0;
        end else begin
            smp_r  <= seven_segment_display_i;
            prev_r <= smp_r;
            cnt_r  <= cnt_s;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SYNC;
            mask_r  <= 4'b0000;
            dig_r   <= '0;
            min_o   <= 6'd0;
            sec_o   <= 6'd0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_r <= state_n;
            mask_r  <= mask_n;
            dig_r   <= dig_n;
            min_o   <= min_n;
            sec_o   <= sec_n;
            valid_o <= valid_n;
            err_o   <= err_n;
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: two instances (STABLE_CNT=1 and 3) share one
// input stream and are compared every cycle against a frame-level reference model.
module tb_seven_segment_capture;

    logic        clk_core = 1'b0;
    logic        rst_n    = 1'b0;
    logic [10:0] din      = 11'h7FF;
    logic [5:0]  min1, sec1, min3, sec3;
    logic        val1, err1, val3, err3;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100};

    int          sn [2] = '{1, 3};
    logic [10:0] lastv;
    bit          started;
    int          run;
    bit          open_m [2];
    bit          have_m [2][4];
    int          dig_m  [2][4];
    int          emin   [2];
    int          esec   [2];
    logic [13:0] e1 [2];
    logic [13:0] e2 [2];

    seven_segment_capture #(.STABLE_CNT(1)) dut1 (
        .clk_core(clk_core), .rst_n(rst_n), .seven_segment_display_i(din),
        .min_o(min1), .sec_o(sec1), .valid_o(val1), .err_o(err1));

    seven_segment_capture #(.STABLE_CNT(3)) dut3 (
        .clk_core(clk_core), .rst_n(rst_n), .seven_segment_display_i(din),
        .min_o(min3), .sec_o(sec3), .valid_o(val3), .err_o(err3));

    always #5 clk_core = ~clk_core;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] dg(input logic [3:0] an, input int d);
        logic [6:0] s;
        s = seg_tab[d];
        return {an, s};
    endfunction

    task automatic take(input int k, input int slot, input int dv, output bit v, output bit e);
        int m, s;
        v = 1'b0;
        e = 1'b0;
        if (!open_m[k]) begin
            if (slot == 0) begin
                open_m[k] = 1'b1;
                for (int i = 0; i < 4; i++) have_m[k][i] = 1'b0;
                have_m[k][0] = 1'b1;
                dig_m[k][0]  = dv;
            end
        end else if (have_m[k][slot]) begin
            e = 1'b1;
            for (int i = 0; i < 4; i++) have_m[k][i] = 1'b0;
            if (slot == 0) begin
                have_m[k][0] = 1'b1;
                dig_m[k][0]  = dv;
            end else begin
                open_m[k] = 1'b0;
            end
        end else begin
            have_m[k][slot] = 1'b1;
            dig_m[k][slot]  = dv;
            if (have_m[k][0] && have_m[k][1] && have_m[k][2] && have_m[k][3]) begin
                m = dig_m[k][0] * 10 + dig_m[k][1];
                s = dig_m[k][2] * 10 + dig_m[k][3];
                open_m[k] = 1'b0;
                if (m <= 63 && s <= 63) begin
                    emin[k] = m;
                    esec[k] = s;
                    v = 1'b1;
                end else begin
                    e = 1'b1;
                end
            end
        end
    endtask

    // Feeds one input value to the model; the result is visible two negedges later.
    task automatic step(input logic [10:0] x);
        int slot, dv;
        bit v, e;
        if (started && x == lastv) run++;
        else run = 1;
        lastv   = x;
        started = 1'b1;
        case (x[10:7])
            4'b0111: slot = 0;
            4'b1011: slot = 1;
            4'b1101: slot = 2;
            4'b1110: slot = 3;
            default: slot = -1;
        endcase
        dv = -1;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == x[6:0]) dv = i;
        for (int k = 0; k < 2; k++) begin
            v = 1'b0;
            e = 1'b0;
            if (x[10:7] == 4'b1111) begin
                e = 1'b0;
            end else if (slot < 0) begin
                e = (run == 1);
            end else if (run == sn[k]) begin
                if (dv < 0) e = 1'b1;
                else take(k, slot, dv, v, e);
            end
            e2[k] = e1[k];
            e1[k] = {v, e, emin[k][5:0], esec[k][5:0]};
        end
    endtask

    task automatic check_outputs();
        chk("valid_s1", 8'(val1), 8'(e2[0][13]));
        chk("err_s1",   8'(err1), 8'(e2[0][12]));
        chk("min_s1",   8'(min1), 8'(e2[0][11:6]));
        chk("sec_s1",   8'(sec1), 8'(e2[0][5:0]));
        chk("valid_s3", 8'(val3), 8'(e2[1][13]));
        chk("err_s3",   8'(err3), 8'(e2[1][12]));
        chk("min_s3",   8'(min3), 8'(e2[1][11:6]));
        chk("sec_s3",   8'(sec3), 8'(e2[1][5:0]));
    endtask

    task automatic cyc(input logic [10:0] x);
        @(negedge clk_core);
        check_outputs();
        step(x);
        din = x;
    endtask

    task automatic hold(input logic [10:0] x, input int n);
        repeat (n) cyc(x);
    endtask

    task automatic do_reset();
        @(negedge clk_core);
        rst_n = 1'b0;
        din   = 11'h7FF;
        #1;
        chk("rst_min1", 8'(min1), 8'd0);
        chk("rst_sec1", 8'(sec1), 8'd0);
        chk("rst_val1", 8'(val1), 8'd0);
        chk("rst_err1", 8'(err1), 8'd0);
        chk("rst_min3", 8'(min3), 8'd0);
        chk("rst_sec3", 8'(sec3), 8'd0);
        @(negedge clk_core);
        rst_n   = 1'b1;
        started = 1'b0;
        run     = 0;
        for (int k = 0; k < 2; k++) begin
            open_m[k] = 1'b0;
            for (int i = 0; i < 4; i++) have_m[k][i] = 1'b0;
            emin[k] = 0;
            esec[k] = 0;
            e1[k]   = '0;
            e2[k]   = '0;
        end
        step(11'h7FF);
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] sg;
        int d, h, r;

        do_reset();

        // Basic frame 12:34
        cyc(dg(4'b0111, 1)); cyc(dg(4'b1011, 2)); cyc(dg(4'b1101, 3)); cyc(dg(4'b1110, 4));
        hold(11'h7FF, 3);
        chk("frame_min", 8'(min1), 8'd12);
        chk("frame_sec", 8'(sec1), 8'd34);

        // Leading seconds digits are dropped before sync
        cyc(dg(4'b1101, 5)); cyc(dg(4'b1110, 9));
        cyc(dg(4'b0111, 6)); cyc(dg(4'b1011, 3)); cyc(dg(4'b1101, 0)); cyc(dg(4'b1110, 0));
        hold(11'h7FF, 3);
        chk("sync_min", 8'(min1), 8'd63);
        chk("sync_sec", 8'(sec1), 8'd0);

        // 64 minutes is out of range
        cyc(dg(4'b0111, 6)); cyc(dg(4'b1011, 4)); cyc(dg(4'b1101, 0)); cyc(dg(4'b1110, 0));
        hold(11'h7FF, 3);
        chk("range_min", 8'(min1), 8'd63);

        // Bad anode, illegal segments, then a good frame
        cyc({4'b0011, seg_tab[5]});
        cyc({4'b1011, 7'b1111110});
        cyc(dg(4'b0111, 0)); cyc(dg(4'b1011, 0)); cyc(dg(4'b1101, 5)); cyc(dg(4'b1110, 9));
        hold(11'h7FF, 3);
        chk("decode_sec", 8'(sec1), 8'd59);

        // Stability: held 3 accepts in both, held 2 only in the STABLE_CNT=1 copy
        hold(dg(4'b0111, 2), 3); hold(dg(4'b1011, 3), 3);
        hold(dg(4'b1101, 4), 3); hold(dg(4'b1110, 5), 3);
        hold(11'h7FF, 3);
        chk("stab_min3", 8'(min3), 8'd23);
        chk("stab_sec3", 8'(sec3), 8'd45);
        hold(dg(4'b0111, 1), 2); hold(dg(4'b1011, 1), 2);
        hold(dg(4'b1101, 1), 2); hold(dg(4'b1110, 1), 2);
        hold(11'h7FF, 3);
        chk("short_min3", 8'(min3), 8'd23);
        chk("short_min1", 8'(min1), 8'd11);

        // Reset mid-frame, then an unsynchronised tail, then a full frame
        hold(dg(4'b0111, 4), 3); hold(dg(4'b1011, 2), 3);
        do_reset();
        hold(dg(4'b1011, 3), 3); hold(dg(4'b1101, 1), 3); hold(dg(4'b1110, 2), 3);
        hold(11'h7FF, 2);
        chk("postrst_min1", 8'(min1), 8'd0);
        hold(dg(4'b0111, 0), 3); hold(dg(4'b1011, 7), 3);
        hold(dg(4'b1101, 2), 3); hold(dg(4'b1110, 8), 3);
        hold(11'h7FF, 3);
        chk("postrst_min3", 8'(min3), 8'd7);
        chk("postrst_sec3", 8'(sec3), 8'd28);

        // Randomised frames with occasional corruption, blanks and resets
        for (int f = 0; f < 80; f++) begin
            if (f % 27 == 13) do_reset();
            for (int s = 0; s < 4; s++) begin
                case (s)
                    0:       an = 4'b0111;
                    1:       an = 4'b1011;
                    2:       an = 4'b1101;
                    default: an = 4'b1110;
                endcase
                r = $urandom_range(0, 19);
                if (r == 0) an = 4'($urandom);
                else if (r == 1) an = 4'b1111;
                d  = (s == 0 || s == 2) ? $urandom_range(0, 7) : $urandom_range(0, 9);
                sg = seg_tab[d];
                if ($urandom_range(0, 24) == 0) sg = 7'($urandom);
                h = $urandom_range(1, 4);
                hold({an, sg}, h);
                if ($urandom_range(0, 9) == 0) cyc(11'h7FF);
            end
        end
        hold(11'h7FF, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
